// File: rtl/jtag_tap_ir.sv
// IEEE 1149.1 TAP controller with instruction register, BYPASS/IDCODE and user DR selects.
// All state sits on TCK; the optional IDCODE register is built when TAP_IDCODE_EN is defined.
module jtag_tap_ir #(
  parameter int unsigned IR_WIDTH     = 4,
  parameter int unsigned NUM_DR       = 2,
  parameter int unsigned USER_BASE    = 2,
  parameter int unsigned IDCODE_OP    = 1,
  parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
  input  logic                TCK,
  input  logic                Reset,
  input  logic                TMS,
  input  logic                TDI,
  input  logic [NUM_DR-1:0]   DrTdo,
  output logic                TDO,
  output logic                Enable,
  output logic                Select,
  output logic                CaptureDR,
  output logic                ShiftDR,
  output logic                ClockDR,
  output logic                UpdateDR,
  output logic                ShiftIR,
  output logic                ClockIR,
  output logic                UpdateIR,
  output logic [NUM_DR-1:0]   DrSelect,
  output logic [IR_WIDTH-1:0] Instruction
);

  typedef enum logic [3:0] {
    StTestLogicReset,
    StRunTestIdle,
    StSelectDrScan,
    StCaptureDr,
    StShiftDr,
    StExit1Dr,
    StPauseDr,
    StExit2Dr,
    StUpdateDr,
    StSelectIrScan,
    StCaptureIr,
    StShiftIr,
    StExit1Ir,
    StPauseIr,
    StExit2Ir,
    StUpdateIr
  } state_e;

`ifdef TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] InstrReset = IR_WIDTH'(IDCODE_OP);
`else
  localparam logic [IR_WIDTH-1:0] InstrReset = '1;
`endif
  localparam logic [IR_WIDTH-1:0] IrCapture = IR_WIDTH'(2'b01);

  state_e                state_q, state_d;
  logic [IR_WIDTH-1:0]   ir_q, ir_d;
  logic [IR_WIDTH-1:0]   instr_q, instr_d;
  logic                  bypass_q, bypass_d;
  logic                  tdo_q, tdo_d;
`ifdef TAP_IDCODE_EN
  logic [31:0]           idcode_q, idcode_d;
`endif

  logic                  sel_idcode;
  logic                  sel_bypass;
  logic [NUM_DR-1:0]     dr_select;
  logic                  dr_tdo;

  // Instruction decode; all-ones and any unrecognised opcode fall back to BYPASS.
  always_comb begin
    sel_idcode = 1'b0;
    dr_select  = '0;
    if (instr_q != '1) begin
`ifdef TAP_IDCODE_EN
      sel_idcode = (instr_q == IR_WIDTH'(IDCODE_OP));
`endif
      for (int unsigned k = 0; k < NUM_DR; k++) begin
        if (!sel_idcode && (instr_q == IR_WIDTH'(USER_BASE + k))) begin
          dr_select[k] = 1'b1;
        end
      end
    end
    sel_bypass = !sel_idcode && (dr_select == '0);
  end

`ifdef TAP_IDCODE_EN
  assign dr_tdo = (|(DrTdo & dr_select)) | (sel_bypass & bypass_q) | (sel_idcode & idcode_q[0]);
`else
  assign dr_tdo = (|(DrTdo & dr_select)) | (sel_bypass & bypass_q);
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StTestLogicReset: state_d = TMS ? StTestLogicReset : StRunTestIdle;
      StRunTestIdle:    state_d = TMS ? StSelectDrScan   : StRunTestIdle;
      StSelectDrScan:   state_d = TMS ? StSelectIrScan   : StCaptureDr;
      StCaptureDr:      state_d = TMS ? StExit1Dr        : StShiftDr;
      StShiftDr:        state_d = TMS ? StExit1Dr        : StShiftDr;
      StExit1Dr:        state_d = TMS ? StUpdateDr       : StPauseDr;
      StPauseDr:        state_d = TMS ? StExit2Dr        : StPauseDr;
      StExit2Dr:        state_d = TMS ? StUpdateDr       : StShiftDr;
      StUpdateDr:       state_d = TMS ? StSelectDrScan   : StRunTestIdle;
      StSelectIrScan:   state_d = TMS ? StTestLogicReset : StCaptureIr;
      StCaptureIr:      state_d = TMS ? StExit1Ir        : StShiftIr;
      StShiftIr:        state_d = TMS ? StExit1Ir        : StShiftIr;
      StExit1Ir:        state_d = TMS ? StUpdateIr       : StPauseIr;
      StPauseIr:        state_d = TMS ? StExit2Ir        : StPauseIr;
      StExit2Ir:        state_d = TMS ? StUpdateIr       : StShiftIr;
      StUpdateIr:       state_d = TMS ? StSelectDrScan   : StRunTestIdle;
    endcase
    if (Reset) begin
      state_d = StTestLogicReset;
    end
  end

  always_comb begin
    ir_d     = ir_q;
    instr_d  = instr_q;
    bypass_d = bypass_q;
    tdo_d    = 1'b0;
`ifdef TAP_IDCODE_EN
    idcode_d = idcode_q;
`endif
    case (state_q)
      StCaptureIr: ir_d = IrCapture;
      StShiftIr: begin
        ir_d  = {TDI, ir_q[IR_WIDTH-1:1]};
        tdo_d = ir_q[0];
      end
      StUpdateIr: instr_d = ir_q;
      StCaptureDr: begin
        if (sel_bypass) bypass_d = 1'b0;
`ifdef TAP_IDCODE_EN
        if (sel_idcode) idcode_d = IDCODE_VALUE;
`endif
      end
      StShiftDr: begin
        tdo_d = dr_tdo;
        if (sel_bypass) bypass_d = TDI;
`ifdef TAP_IDCODE_EN
        if (sel_idcode) idcode_d = {TDI, idcode_q[31:1]};
`endif
      end
      default: ;
    endcase
    // Entering Test_Logic_Reset (by Reset or by TMS) discards any partial scan.
    if (state_d == StTestLogicReset) begin
      ir_d     = '0;
      instr_d  = InstrReset;
      bypass_d = 1'b0;
      tdo_d    = 1'b0;
`ifdef TAP_IDCODE_EN
      idcode_d = IDCODE_VALUE;
`endif
    end
  end

  always_ff @(posedge TCK) begin
    if (Reset) begin
      state_q  <= StTestLogicReset;
      ir_q     <= '0;
      instr_q  <= InstrReset;
      bypass_q <= 1'b0;
      tdo_q    <= 1'b0;
`ifdef TAP_IDCODE_EN
      idcode_q <= IDCODE_VALUE;
`endif
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      instr_q  <= instr_d;
      bypass_q <= bypass_d;
      tdo_q    <= tdo_d;
`ifdef TAP_IDCODE_EN
      idcode_q <= idcode_d;
`endif
    end
  end

  always_comb begin
    CaptureDR = (state_q == StCaptureDr);
    ShiftDR   = (state_q == StShiftDr);
    UpdateDR  = (state_q == StUpdateDr);
    ClockDR   = (state_q == StCaptureDr) || (state_q == StShiftDr);
    ShiftIR   = (state_q == StShiftIr);
    UpdateIR  = (state_q == StUpdateIr);
    ClockIR   = (state_q == StCaptureIr) || (state_q == StShiftIr);
    Enable    = (state_q == StShiftDr) || (state_q == StShiftIr);
    Select    = 1'b0;
    case (state_q)
      StTestLogicReset, StSelectIrScan, StCaptureIr, StShiftIr,
      StExit1Ir, StPauseIr, StExit2Ir, StUpdateIr: Select = 1'b1;
      default: ;
    endcase
  end

  assign TDO         = tdo_q;
  assign DrSelect    = dr_select;
  assign Instruction = instr_q;

endmodule

// File: tb/tb_jtag_tap_ir.sv
// Self-checking bench for jtag_tap_ir: directed scans plus a random TMS/TDI walk
// checked against a table-driven TAP model.
module tb_jtag_tap_ir;
  localparam int NDR = 2;

`ifdef TAP_IDCODE_EN
  localparam logic [3:0] RST_INSTR = 4'h1;
  localparam bit         HAS_ID    = 1'b1;
`else
  localparam logic [3:0] RST_INSTR = 4'hF;
  localparam bit         HAS_ID    = 1'b0;
`endif
  localparam logic [31:0] ID_VAL = 32'h1000_0001;

  // IEEE 1149.1 state numbering used only by the model
  localparam int S_TLR = 0, S_CDR = 3, S_SHDR = 4, S_UDR = 8, S_SIS = 9;
  localparam int S_CIR = 10, S_SHIR = 11, S_UIR = 15;
  int ns0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int ns1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  logic TCK = 1'b0, Reset = 1'b0, TMS = 1'b0, TDI = 1'b0;
  logic [NDR-1:0] DrTdo = '0;
  logic TDO, Enable, Select, CaptureDR, ShiftDR, ClockDR, UpdateDR, ShiftIR, ClockIR, UpdateIR;
  logic [NDR-1:0] DrSelect;
  logic [3:0] Instruction;

  int checks = 0;
  int errors = 0;

  int          ms = S_TLR;
  logic [3:0]  m_instr = RST_INSTR;
  logic [3:0]  m_ir = '0;
  logic        m_byp = 1'b0;
  logic [31:0] m_idc = ID_VAL;
  logic        m_tdo = 1'b0;
  logic [NDR-1:0] last_drtdo = '0;

  jtag_tap_ir dut (
    .TCK(TCK), .Reset(Reset), .TMS(TMS), .TDI(TDI), .DrTdo(DrTdo), .TDO(TDO),
    .Enable(Enable), .Select(Select), .CaptureDR(CaptureDR), .ShiftDR(ShiftDR),
    .ClockDR(ClockDR), .UpdateDR(UpdateDR), .ShiftIR(ShiftIR), .ClockIR(ClockIR),
    .UpdateIR(UpdateIR), .DrSelect(DrSelect), .Instruction(Instruction)
  );

  always #5 TCK = ~TCK;

  // -1 = BYPASS, -2 = IDCODE, k >= 0 = user DR k
  function automatic int kind(input logic [3:0] op);
    if (op == 4'hF) return -1;
    if (HAS_ID && op == 4'h1) return -2;
    if (op >= 4'd2 && int'(op) < 2 + NDR) return int'(op) - 2;
    return -1;
  endfunction

  task automatic tick(input logic r, input logic tms, input logic tdi);
    int k;
    int nxt;
    Reset = r; TMS = tms; TDI = tdi; DrTdo = NDR'($urandom);
    @(posedge TCK);
    last_drtdo = DrTdo;
    k   = kind(m_instr);
    nxt = r ? S_TLR : (tms ? ns1[ms] : ns0[ms]);
    if (ms == S_SHIR) m_tdo = m_ir[0];
    else if (ms == S_SHDR) m_tdo = (k == -1) ? m_byp : (k == -2) ? m_idc[0] : DrTdo[k];
    else m_tdo = 1'b0;
    if (ms == S_CIR) m_ir = 4'b0001;
    if (ms == S_SHIR) m_ir = {tdi, m_ir[3:1]};
    if (ms == S_UIR) m_instr = m_ir;
    if (ms == S_CDR && k == -1) m_byp = 1'b0;
    if (ms == S_CDR && k == -2) m_idc = ID_VAL;
    if (ms == S_SHDR && k == -1) m_byp = tdi;
    if (ms == S_SHDR && k == -2) m_idc = {tdi, m_idc[31:1]};
    if (nxt == S_TLR) begin
      m_instr = RST_INSTR; m_ir = '0; m_byp = 1'b0; m_tdo = 1'b0; m_idc = ID_VAL;
    end
    ms = nxt;
    #1;
  endtask

  // From Run_Test_Idle: load an IR value LSB first, return the shifted-out bits.
  task automatic load_ir(input logic [3:0] v, output logic [3:0] cap, output logic upd);
    tick(0, 1, 0); tick(0, 1, 0); tick(0, 0, 0); tick(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick(0, i == 3, v[i]);
      cap[i] = TDO;
    end
    tick(0, 1, 0);
    upd = UpdateIR;
    tick(0, 0, 0);
  endtask

  // From Run_Test_Idle: capture and shift n DR bits, return TDO and user-DR bits seen.
  task automatic scan_dr(input int n, input logic [31:0] tin, output logic [31:0] tout,
                         output logic [31:0] uout);
    tout = '0; uout = '0;
    tick(0, 1, 0); tick(0, 0, 0); tick(0, 0, 0);
    for (int i = 0; i < n; i++) begin
      tick(0, i == n - 1, tin[i]);
      tout[i] = TDO;
      uout[i] = last_drtdo[1];
    end
    tick(0, 1, 0); tick(0, 0, 0);
  endtask

  task automatic test_reset();
    tick(1, 1, 0); tick(1, 0, 1);
    checks++;
    if (Instruction !== RST_INSTR) begin
      errors++; $display("FAIL reset_instr: got %h expected %h", Instruction, RST_INSTR);
    end
    checks++;
    if ({CaptureDR, ShiftDR, ClockDR, UpdateDR, ShiftIR, ClockIR, UpdateIR, Enable, TDO,
         DrSelect} !== '0) begin
      errors++; $display("FAIL reset_strobes: got nonzero strobes/TDO/DrSelect expected 0");
    end
    checks++;
    if (Select !== 1'b1) begin errors++; $display("FAIL reset_select: got %b expected 1", Select); end
    tick(0, 0, 0);
    checks++;
    if ({Select, CaptureDR, ShiftDR, ClockDR, UpdateDR, ShiftIR, ClockIR, UpdateIR, Enable}
        !== '0 || Instruction !== RST_INSTR) begin
      errors++; $display("FAIL idle_after_reset: select %b instr %h expected 0 / %h",
                         Select, Instruction, RST_INSTR);
    end
  endtask

  task automatic test_idcode_scan();
    logic [31:0] stream, exp;
    exp = HAS_ID ? ID_VAL : 32'h0;
    tick(0, 1, 0); tick(0, 0, 0);
    checks++;
    if ({CaptureDR, ClockDR, Enable} !== 3'b110) begin
      errors++; $display("FAIL capture_dr: got %b expected 110", {CaptureDR, ClockDR, Enable});
    end
    tick(0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      checks++;
      if ({Enable, ShiftDR, ClockDR} !== 3'b111) begin
        errors++; $display("FAIL shift_dr_enable bit %0d: got %b expected 111", i,
                           {Enable, ShiftDR, ClockDR});
      end
      tick(0, i == 31, 0);
      stream[i] = TDO;
    end
    checks++;
    if (stream !== exp) begin
      errors++; $display("FAIL idcode_stream: got %h expected %h", stream, exp);
    end
    checks++;
    if (Enable !== 1'b0) begin errors++; $display("FAIL exit1_enable: got %b expected 0", Enable); end
    tick(0, 1, 0);
    checks++;
    if (UpdateDR !== 1'b1) begin errors++; $display("FAIL update_dr: got %b expected 1", UpdateDR); end
    tick(0, 0, 0);
  endtask

  task automatic test_ir_user();
    logic [3:0] cap;
    logic upd;
    logic [31:0] tout, uout;
    load_ir(4'b0011, cap, upd);
    checks++;
    if (cap !== 4'b0001) begin errors++; $display("FAIL ir_capture: got %b expected 0001", cap); end
    checks++;
    if (upd !== 1'b1) begin errors++; $display("FAIL update_ir: got %b expected 1", upd); end
    checks++;
    if (Instruction !== 4'h3 || DrSelect !== 2'b10) begin
      errors++; $display("FAIL user_decode: got instr %h sel %b expected 3 / 10",
                         Instruction, DrSelect);
    end
    scan_dr(8, $urandom, tout, uout);
    checks++;
    if (tout[7:0] !== uout[7:0]) begin
      errors++; $display("FAIL user_dr_tdo: got %b expected %b", tout[7:0], uout[7:0]);
    end
  endtask

  task automatic test_bypass();
    logic [3:0] cap;
    logic upd;
    logic [31:0] tout, uout;
    load_ir(4'hF, cap, upd);
    checks++;
    if (Instruction !== 4'hF || DrSelect !== 2'b00) begin
      errors++; $display("FAIL bypass_decode: got instr %h sel %b expected F / 00",
                         Instruction, DrSelect);
    end
    scan_dr(4, 32'b1101, tout, uout);
    checks++;
    if (tout[3:0] !== 4'b1010) begin
      errors++; $display("FAIL bypass_stream: got %b expected 1010", tout[3:0]);
    end
  endtask

  task automatic test_undecoded();
    logic [3:0] cap;
    logic upd;
    logic [31:0] tin, tout, uout;
    load_ir(4'h7, cap, upd);
    checks++;
    if (Instruction !== 4'h7 || DrSelect !== 2'b00) begin
      errors++; $display("FAIL undecoded_decode: got instr %h sel %b expected 7 / 00",
                         Instruction, DrSelect);
    end
    tin = $urandom;
    scan_dr(8, tin, tout, uout);
    checks++;
    if (tout[7:0] !== {tin[6:0], 1'b0}) begin
      errors++; $display("FAIL undecoded_bypass: got %b expected %b", tout[7:0], {tin[6:0], 1'b0});
    end
  endtask

  task automatic test_reset_mid_ir();
    tick(0, 1, 0); tick(0, 1, 0); tick(0, 0, 0); tick(0, 0, 0);
    tick(0, 0, 1); tick(0, 0, 0);
    checks++;
    if (ShiftIR !== 1'b1) begin errors++; $display("FAIL mid_shift_ir: got %b expected 1", ShiftIR); end
    tick(1, 0, 1);
    checks++;
    if ({Select, ShiftIR, UpdateIR, TDO} !== 4'b1000 || Instruction !== RST_INSTR) begin
      errors++; $display("FAIL reset_mid_ir: got %b instr %h expected 1000 / %h",
                         {Select, ShiftIR, UpdateIR, TDO}, Instruction, RST_INSTR);
    end
    tick(0, 0, 0);
    checks++;
    if (UpdateIR !== 1'b0 || Instruction !== RST_INSTR) begin
      errors++; $display("FAIL after_reset_mid_ir: got upd %b instr %h expected 0 / %h",
                         UpdateIR, Instruction, RST_INSTR);
    end
  endtask

  task automatic test_tms_reset();
    logic [3:0] cap;
    logic upd;
    load_ir(4'h3, cap, upd);
    tick(0, 1, 0); tick(0, 0, 0); tick(0, 0, 0);
    checks++;
    if (ShiftDR !== 1'b1) begin errors++; $display("FAIL tms_reset_start: got %b expected 1", ShiftDR); end
    for (int i = 0; i < 4; i++) tick(0, 1, 0);
    checks++;
    if (Instruction !== 4'h3) begin
      errors++; $display("FAIL tms_reset_early: got %h expected 3", Instruction);
    end
    tick(0, 1, 0);
    checks++;
    if (Select !== 1'b1 || Instruction !== RST_INSTR || DrSelect !== 2'b00 ||
        {CaptureDR, ShiftDR, ClockDR, UpdateDR, ShiftIR, ClockIR, UpdateIR, Enable} !== '0) begin
      errors++; $display("FAIL tms_reset: got select %b instr %h sel %b expected 1 / %h / 00",
                         Select, Instruction, DrSelect, RST_INSTR);
    end
  endtask

  task automatic test_random();
    logic [9:0] got, exp;
    logic [NDR-1:0] exp_sel;
    int k;
    tick(1, 0, 0);
    for (int n = 0; n < 800; n++) begin
      tick($urandom_range(0, 63) == 0, $urandom_range(0, 9) < 4, 1'($urandom));
      got = {TDO, Enable, Select, CaptureDR, ShiftDR, ClockDR, UpdateDR, ShiftIR, ClockIR, UpdateIR};
      exp = {m_tdo, ms == S_SHDR || ms == S_SHIR, ms == S_TLR || ms >= S_SIS, ms == S_CDR,
             ms == S_SHDR, ms == S_CDR || ms == S_SHDR, ms == S_UDR, ms == S_SHIR,
             ms == S_CIR || ms == S_SHIR, ms == S_UIR};
      k = kind(m_instr);
      exp_sel = (k >= 0) ? NDR'(1 << k) : '0;
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL random_outputs cycle %0d: got %b expected %b", n, got, exp);
      end
      checks++;
      if (Instruction !== m_instr) begin
        errors++; $display("FAIL random_instr cycle %0d: got %h expected %h", n, Instruction, m_instr);
      end
      checks++;
      if (DrSelect !== exp_sel) begin
        errors++; $display("FAIL random_drselect cycle %0d: got %b expected %b", n, DrSelect, exp_sel);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idcode_scan();
    test_ir_user();
    test_bypass();
    test_undecoded();
    test_reset_mid_ir();
    test_tms_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
